// File: rtl/apb_master_bridge.sv
// Core data-bus to APB3 master bridge. Decodes the peripheral window, steers
// store lanes, extends load data and aborts transfers to slaves that never respond.
module apb_master_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          NUM_SLAVES = 4,
    parameter int          TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      d_req,
    input  logic                      d_wr_en,
    input  logic [31:0]               dAddr,
    input  logic [31:0]               dWdata,
    input  logic [2:0]                store_type,
    input  logic [2:0]                load_type,
    output logic [31:0]               dRdata,
    output logic                      d_ready,
    output logic                      d_err,
    output logic [31:0]               PADDR,
    output logic                      PWRITE,
    output logic [NUM_SLAVES-1:0]     PSEL,
    output logic                      PENABLE,
    output logic [31:0]               PWDATA,
    output logic [3:0]                PSTRB,
    input  logic [32*NUM_SLAVES-1:0]  PRDATA,
    input  logic [NUM_SLAVES-1:0]     PREADY,
    input  logic [NUM_SLAVES-1:0]     PSLVERR
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t                r_state, w_state;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [3:0]            r_idx, w_idx_n;
    logic [1:0]            r_off, w_off_n;
    size_t                 r_size, w_size_n;
    logic                  r_uns, w_uns_n;
    logic [NUM_SLAVES-1:0] r_psel, w_psel;
    logic                  r_penable, w_penable;
    logic [31:0]           r_paddr, w_paddr;
    logic                  r_pwrite, w_pwrite;
    logic [31:0]           r_pwdata, w_pwdata;
    logic [3:0]            r_pstrb, w_pstrb;
    logic [31:0]           r_rdata, w_rdata;
    logic                  r_ready, w_ready;
    logic                  r_err, w_err;

    // Request decode
    size_t                 w_size;
    logic                  w_uns, w_in_win, w_idx_ok, w_misal;
    logic [1:0]            w_off;
    logic [3:0]            w_idx;
    logic [3:0]            w_strb;
    logic [31:0]           w_wdata;
    logic [NUM_SLAVES-1:0] w_onehot;

    always_comb begin
        w_off = dAddr[1:0];
        w_idx = dAddr[15:12];
        w_uns = 1'b0;
        if (d_wr_en) begin
            case (store_type)
                3'b000:  w_size = SZ_B;
                3'b001:  w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end else begin
            case (load_type)
                3'b000:  w_size = SZ_B;
                3'b001:  w_size = SZ_H;
                3'b100:  begin w_size = SZ_B; w_uns = 1'b1; end
                3'b101:  begin w_size = SZ_H; w_uns = 1'b1; end
                default: w_size = SZ_W;
            endcase
        end
        w_in_win = (dAddr[31:16] == BASE_ADDR[31:16]);
        w_idx_ok = (int'(w_idx) < NUM_SLAVES);
        w_misal  = ((w_size == SZ_H) && w_off[0]) || ((w_size == SZ_W) && (w_off != 2'b00));

        case (w_size)
            SZ_B:    begin w_strb = 4'b0001 << w_off;           w_wdata = {4{dWdata[7:0]}};  end
            SZ_H:    begin w_strb = 4'b0011 << {w_off[1], 1'b0}; w_wdata = {2{dWdata[15:0]}}; end
            default: begin w_strb = 4'hF;                        w_wdata = dWdata;           end
        endcase
        if (!d_wr_en) begin
            w_strb  = 4'h0;
            w_wdata = 32'h0;
        end

        w_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (w_idx == 4'(i)) w_onehot[i] = 1'b1;
    end

    // Selected-slave response and load extraction
    logic [31:0] w_prdata, w_sh_b, w_sh_h, w_ld_data;
    logic        w_pready, w_pslverr;

    always_comb begin
        w_prdata  = 32'h0;
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == 4'(i)) begin
                w_prdata  = PRDATA[32*i +: 32];
                w_pready  = PREADY[i];
                w_pslverr = PSLVERR[i];
            end
        end
        w_sh_b = w_prdata >> {r_off, 3'b000};
        w_sh_h = w_prdata >> {r_off[1], 4'b0000};
        case (r_size)
            SZ_B:    w_ld_data = r_uns ? {24'h0, w_sh_b[7:0]}  : {{24{w_sh_b[7]}}, w_sh_b[7:0]};
            SZ_H:    w_ld_data = r_uns ? {16'h0, w_sh_h[15:0]} : {{16{w_sh_h[15]}}, w_sh_h[15:0]};
            default: w_ld_data = w_prdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        // NOTE: every next value defaults to its held value first, so no branch leaves one unassigned and infers a latch.
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx_n   = r_idx;
        w_off_n   = r_off;
        w_size_n  = r_size;
        w_uns_n   = r_uns;
        w_psel    = r_psel;
        w_penable = r_penable;
        w_paddr   = r_paddr;
        w_pwrite  = r_pwrite;
        w_pwdata  = r_pwdata;
        w_pstrb   = r_pstrb;
        w_rdata   = r_rdata;
        w_err     = r_err;
        w_ready   = 1'b0;

        case (r_state)
            IDLE: begin
                if (d_req) begin
                    if (!w_in_win || !w_idx_ok || w_misal) begin
                        w_state = DONE;
                        w_ready = 1'b1;
                        w_err   = 1'b1;
                        w_rdata = 32'h0;
                    end else begin
                        w_state   = SETUP;
                        w_idx_n   = w_idx;
                        w_off_n   = w_off;
                        w_size_n  = w_size;
                        w_uns_n   = w_uns;
                        w_psel    = w_onehot;
                        w_penable = 1'b0;
                        w_paddr   = {dAddr[31:2], 2'b00};
                        w_pwrite  = d_wr_en;
                        w_pwdata  = w_wdata;
                        w_pstrb   = w_strb;
                    end
                end
            end
            SETUP: begin
                w_state   = ACCESS;
                w_penable = 1'b1;
                w_cnt     = '0;
            end
            ACCESS: begin
                if (w_pready) begin
                    w_state   = DONE;
                    w_psel    = '0;
                    w_penable = 1'b0;
                    w_ready   = 1'b1;
                    w_err     = w_pslverr;
                    w_rdata   = r_pwrite ? 32'h0 : w_ld_data;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    // Dead slave: give the core an error instead of stalling forever.
                    w_state   = DONE;
                    w_psel    = '0;
                    w_penable = 1'b0;
                    w_ready   = 1'b1;
                    w_err     = 1'b1;
                    w_rdata   = 32'h0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_off     <= '0;
            r_size    <= SZ_B;
            r_uns     <= 1'b0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_rdata   <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx_n;
            r_off     <= w_off_n;
            r_size    <= w_size_n;
            r_uns     <= w_uns_n;
            r_psel    <= w_psel;
            r_penable <= w_penable;
            r_paddr   <= w_paddr;
            r_pwrite  <= w_pwrite;
            r_pwdata  <= w_pwdata;
            r_pstrb   <= w_pstrb;
            r_rdata   <= w_rdata;
            r_ready   <= w_ready;
            r_err     <= w_err;
        end
    end

    assign dRdata  = r_rdata;
    assign d_ready = r_ready;
    assign d_err   = r_err;
    assign PADDR   = r_paddr;
    assign PWRITE  = r_pwrite;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWDATA  = r_pwdata;
    assign PSTRB   = r_pstrb;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed and random core transactions against
// behavioural APB slaves, with expectations derived from address/type arithmetic.
module tb_apb_master_bridge;
    localparam int NS = 4;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               d_req, d_wr_en;
    logic [31:0]        dAddr, dWdata;
    logic [2:0]         store_type, load_type;
    logic [31:0]        dRdata;
    logic               d_ready, d_err;
    logic [31:0]        PADDR;
    logic               PWRITE;
    logic [NS-1:0]      PSEL;
    logic               PENABLE;
    logic [31:0]        PWDATA;
    logic [3:0]         PSTRB;
    logic [32*NS-1:0]   PRDATA;
    logic [NS-1:0]      PREADY, PSLVERR;

    int n_checks = 0;
    int n_errors = 0;
    int n_setup  = 0;

    logic [31:0] prdata_cfg [NS];
    int          wait_cfg   [NS];
    bit          stuck_cfg  [NS];
    bit          err_cfg    [NS];

    apb_master_bridge #(.BASE_ADDR(32'h1000_0000), .NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .d_req(d_req), .d_wr_en(d_wr_en), .dAddr(dAddr),
        .dWdata(dWdata), .store_type(store_type), .load_type(load_type), .dRdata(dRdata),
        .d_ready(d_ready), .d_err(d_err), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    // Behavioural slaves: ready after wait_cfg access cycles unless stuck.
    initial begin
        int acc [NS];
        PREADY  = '0;
        PRDATA  = '0;
        PSLVERR = '0;
        for (int i = 0; i < NS; i++) acc[i] = 0;
        forever begin
            @(negedge clk);
            if ((PSEL != '0) && !PENABLE) n_setup++;
            for (int i = 0; i < NS; i++) begin
                if (PSEL[i] && PENABLE) acc[i]++;
                else acc[i] = 0;
                PREADY[i]          = !stuck_cfg[i] && (acc[i] > wait_cfg[i]);
                PRDATA[32*i +: 32] = prdata_cfg[i];
                PSLVERR[i]         = err_cfg[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] extend(input logic [31:0] word, input int off, input int size, input bit sgn);
        longint v;
        if (size == 4) return word;
        v = (longint'(word) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
        if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
        return v[31:0];
    endfunction

    task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] st, input logic [2:0] lt, input bit hold);
        int idx, size, off, exp_lat, lat, setup0;
        bit sgn, mapped, dec_err, stuck, exp_err, got, saw_psel, paddr_ok;
        logic [31:0] exp_strb, exp_wdata, exp_rdata;

        idx    = int'(addr[15:12]);
        mapped = (addr[31:16] == 16'h1000) && (idx < NS);
        if (wr) size = (st == 3'd0) ? 1 : (st == 3'd1) ? 2 : 4;
        else    size = (lt == 3'd0 || lt == 3'd4) ? 1 : (lt == 3'd1 || lt == 3'd5) ? 2 : 4;
        sgn     = !wr && (lt == 3'd0 || lt == 3'd1);
        off     = int'(addr[1:0]);
        dec_err = !mapped || (off % size != 0);
        stuck   = mapped && stuck_cfg[idx];
        exp_strb = wr ? (((32'd1 << size) - 1) << off) : 32'd0;
        for (int b = 0; b < 4; b++) exp_wdata[8*b +: 8] = wdata[8*(b % size) +: 8];
        exp_lat   = dec_err ? 1 : stuck ? 2 + TO : 3 + wait_cfg[idx];
        exp_err   = dec_err || stuck || err_cfg[idx];
        exp_rdata = (dec_err || stuck) ? 32'd0 : extend(prdata_cfg[idx], off, size, sgn);

        setup0 = n_setup;
        @(posedge clk); #1;
        d_req = 1'b1; d_wr_en = wr; dAddr = addr; dWdata = wdata; store_type = st; load_type = lt;
        lat = 0; got = 0; saw_psel = 0; paddr_ok = 1;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (PSEL != '0) begin
                saw_psel = 1;
                if (PADDR !== (addr & ~32'd3)) paddr_ok = 0;
            end
            if (lat == 1 && !dec_err) begin
                check({tag, " psel"},    32'(PSEL), 32'(1 << idx));
                check({tag, " penable0"}, 32'(PENABLE), 32'd0);
                check({tag, " pwrite"},  32'(PWRITE), 32'(wr));
                check({tag, " pstrb"},   32'(PSTRB), exp_strb);
                if (wr) check({tag, " pwdata"}, PWDATA, exp_wdata);
            end
            if (lat == 2 && !dec_err) check({tag, " penable1"}, 32'(PENABLE), 32'd1);
            if (d_ready) got = 1;
        end
        check({tag, " completed"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " d_err"}, 32'(d_err), 32'(exp_err));
        if (!wr || dec_err || stuck) check({tag, " dRdata"}, dRdata, exp_rdata);
        if (dec_err) check({tag, " no psel"}, 32'(saw_psel), 32'd0);
        else         check({tag, " paddr stable"}, 32'(paddr_ok), 32'd1);
        if (!hold) d_req = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready pulse"}, 32'(d_ready), 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check({tag, " apb transfers"}, 32'(n_setup - setup0), dec_err ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [15:0] hi;
        int          ridx;
        logic [31:0] raddr;
        for (int i = 0; i < NS; i++) begin
            prdata_cfg[i] = 32'h0; wait_cfg[i] = 0; stuck_cfg[i] = 1'b0; err_cfg[i] = 1'b0;
        end
        reset = 1'b1; d_req = 1'b0; d_wr_en = 1'b0; dAddr = '0; dWdata = '0;
        store_type = '0; load_type = '0;
        #12;
        check("reset psel",    32'(PSEL), 32'd0);
        check("reset penable", 32'(PENABLE), 32'd0);
        check("reset d_ready", 32'(d_ready), 32'd0);
        check("reset d_err",   32'(d_err), 32'd0);
        check("reset dRdata",  dRdata, 32'd0);
        check("reset paddr",   PADDR, 32'd0);
        check("reset pstrb",   32'(PSTRB), 32'd0);
        check("reset pwdata",  PWDATA, 32'd0);
        @(negedge clk) reset = 1'b0;

        run_txn("sw slave1", 1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 3'b010, 3'b010, 1'b0);
        check("sw pwdata value", PWDATA, 32'hDEAD_BEEF);
        run_txn("sb lane3", 1'b1, 32'h1000_0003, 32'h0000_00A5, 3'b000, 3'b010, 1'b0);
        check("sb pwdata value", PWDATA, 32'hA5A5_A5A5);

        prdata_cfg[0] = 32'h0080_0000;
        run_txn("lb", 1'b0, 32'h1000_0002, 32'h0, 3'b010, 3'b000, 1'b0);
        check("lb value", dRdata, 32'hFFFF_FF80);
        run_txn("lbu", 1'b0, 32'h1000_0002, 32'h0, 3'b010, 3'b100, 1'b0);
        check("lbu value", dRdata, 32'h0000_0080);

        prdata_cfg[2] = 32'h8001_1234; wait_cfg[2] = 3;
        run_txn("lh wait3", 1'b0, 32'h1000_2002, 32'h0, 3'b010, 3'b001, 1'b0);
        check("lh value", dRdata, 32'hFFFF_8001);
        wait_cfg[2] = 0;

        stuck_cfg[3] = 1'b1;
        run_txn("timeout", 1'b0, 32'h1000_3000, 32'h0, 3'b010, 3'b010, 1'b0);
        run_txn("out of window", 1'b0, 32'h2000_0000, 32'h0, 3'b010, 3'b010, 1'b0);
        run_txn("slave5", 1'b1, 32'h1000_5000, 32'h1234_5678, 3'b010, 3'b010, 1'b0);
        run_txn("misaligned sw", 1'b1, 32'h1000_1002, 32'h1, 3'b010, 3'b010, 1'b0);
        run_txn("misaligned lh", 1'b0, 32'h1000_1001, 32'h0, 3'b010, 3'b101, 1'b0);

        prdata_cfg[1] = 32'hCAFE_F00D; err_cfg[1] = 1'b1;
        run_txn("lw slverr held", 1'b0, 32'h1000_1008, 32'h0, 3'b010, 3'b010, 1'b1);
        check("lw slverr word", dRdata, 32'hCAFE_F00D);
        err_cfg[1] = 1'b0;

        // Reset while the transfer to the stuck slave sits in ACCESS.
        @(posedge clk); #1;
        d_req = 1'b1; d_wr_en = 1'b0; dAddr = 32'h1000_3000; load_type = 3'b010;
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset psel", 32'(PSEL), 32'h8);
        check("pre-reset penable", 32'(PENABLE), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset psel", 32'(PSEL), 32'd0);
        check("async reset penable", 32'(PENABLE), 32'd0);
        check("async reset d_ready", 32'(d_ready), 32'd0);
        @(negedge clk) reset = 1'b0;
        stuck_cfg[3] = 1'b0;
        run_txn("sw after reset", 1'b1, 32'h1000_300C, 32'h0BAD_F00D, 3'b010, 3'b010, 1'b0);

        for (int n = 0; n < 40; n++) begin
            hi    = ($urandom_range(0, 9) == 0) ? 16'h2000 : 16'h1000;
            ridx  = $urandom_range(0, 5);
            raddr = {hi, 4'(ridx), 10'($urandom), 2'($urandom)};
            if (ridx < NS) begin
                wait_cfg[ridx]   = $urandom_range(0, 3);
                prdata_cfg[ridx] = $urandom;
                err_cfg[ridx]    = ($urandom_range(0, 7) == 0);
            end
            run_txn("random", 1'($urandom), raddr, $urandom, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
